// File: rtl/gcd_param_core.sv
// rtl/gcd_param_core.sv - WIDTH-bit binary (Stein) GCD core with Start/Ack handshake and CEN single-step.
// Optional macro GCD_CYCLE_CNT_EN adds a saturating SUB/MULT cycle counter on output Cycles.
module gcd_param_core #(
  parameter int WIDTH  = 8,
  parameter int ICNT_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CEN,
  input  logic              Start,
  input  logic              Ack,
  input  logic [WIDTH-1:0]  Ain,
  input  logic [WIDTH-1:0]  Bin,
  output logic [WIDTH-1:0]  A,
  output logic [WIDTH-1:0]  B,
  output logic [WIDTH-1:0]  AB_GCD,
  output logic [ICNT_W-1:0] i_count,
  output logic              q_I,
  output logic              q_Sub,
  output logic              q_Mult,
  output logic              q_Done
`ifdef GCD_CYCLE_CNT_EN
  ,
  output logic [15:0]       Cycles
`endif
);

  // One-hot encoding so each q_* flag is a direct register bit decode.
  typedef enum logic [3:0] {
    S_I    = 4'b0001,
    S_SUB  = 4'b0010,
    S_MULT = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_gcd;
  logic [ICNT_W-1:0] r_icnt;

  logic w_zero_op;
  assign w_zero_op = (Ain == '0) || (Bin == '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_I;
      r_a     <= '0;
      r_b     <= '0;
      r_gcd   <= '0;
      r_icnt  <= '0;
    end else if (CEN) begin
      case (r_state)
        S_I: begin
          r_a    <= Ain;
          r_b    <= Bin;
          r_icnt <= '0;
          if (Start) begin
            if (w_zero_op) begin
              r_gcd   <= Ain | Bin;
              r_state <= S_DONE;
            end else begin
              r_state <= S_SUB;
            end
          end
        end
        S_SUB: begin
          // Priority order matters: common twos must be stripped before odd reduction.
          if (r_a == r_b) begin
            r_state <= S_MULT;
          end else if (!r_a[0] && !r_b[0]) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_icnt <= r_icnt + ICNT_W'(1);
          end else if (!r_a[0]) begin
            r_a <= r_a >> 1;
          end else if (!r_b[0]) begin
            r_b <= r_b >> 1;
          end else if (r_a > r_b) begin
            r_a <= r_a - r_b;
          end else begin
            r_b <= r_b - r_a;
          end
        end
        S_MULT: begin
          if (r_icnt != '0) begin
            r_a    <= r_a << 1;
            r_icnt <= r_icnt - ICNT_W'(1);
          end else begin
            r_gcd   <= r_a;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (Ack) begin
            r_state <= S_I;
          end
        end
        default: r_state <= S_I;
      endcase
    end
  end

`ifdef GCD_CYCLE_CNT_EN
  logic [15:0] r_cycles;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cycles <= '0;
    end else if (CEN) begin
      if (r_state == S_I && Start) begin
        r_cycles <= '0;
      end else if ((r_state == S_SUB || r_state == S_MULT) && r_cycles != 16'hFFFF) begin
        r_cycles <= r_cycles + 16'd1;
      end
    end
  end

  assign Cycles = r_cycles;
`endif

  assign A       = r_a;
  assign B       = r_b;
  assign AB_GCD  = r_gcd;
  assign i_count = r_icnt;
  assign q_I     = (r_state == S_I);
  assign q_Sub   = (r_state == S_SUB);
  assign q_Mult  = (r_state == S_MULT);
  assign q_Done  = (r_state == S_DONE);

endmodule

// File: tb/tb_gcd_param_core.sv
// tb/tb_gcd_param_core.sv - scoreboard bench for gcd_param_core at WIDTH=8 and WIDTH=16.
module tb_gcd_param_core;

  localparam logic [3:0] ST_I = 4'd1, ST_SUB = 4'd2, ST_MULT = 4'd4, ST_DONE = 4'd8;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic        cen8, start8, ack8;
  logic [7:0]  ain8, bin8, a8, b8, g8;
  logic [3:0]  ic8;
  logic        qi8, qs8, qm8, qd8;
  logic        cen16, start16, ack16;
  logic [15:0] ain16, bin16, a16, b16, g16;
  logic [4:0]  ic16;
  logic        qi16, qs16, qm16, qd16;
`ifdef GCD_CYCLE_CNT_EN
  logic [15:0] cyc8, cyc16;
`endif

  gcd_param_core #(.WIDTH(8), .ICNT_W(4)) dut8 (
    .Clk(Clk), .Reset(Reset), .CEN(cen8), .Start(start8), .Ack(ack8),
    .Ain(ain8), .Bin(bin8), .A(a8), .B(b8), .AB_GCD(g8), .i_count(ic8),
    .q_I(qi8), .q_Sub(qs8), .q_Mult(qm8), .q_Done(qd8)
`ifdef GCD_CYCLE_CNT_EN
    , .Cycles(cyc8)
`endif
  );

  gcd_param_core #(.WIDTH(16), .ICNT_W(5)) dut16 (
    .Clk(Clk), .Reset(Reset), .CEN(cen16), .Start(start16), .Ack(ack16),
    .Ain(ain16), .Bin(bin16), .A(a16), .B(b16), .AB_GCD(g16), .i_count(ic16),
    .q_I(qi16), .q_Sub(qs16), .q_Mult(qm16), .q_Done(qd16)
`ifdef GCD_CYCLE_CNT_EN
    , .Cycles(cyc16)
`endif
  );

  int checks = 0;
  int errors = 0;
  int exp8_q[$];
  int exp16_q[$];

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Euclid by remainder: deliberately a different algorithm from the DUT.
  function automatic int ref_gcd(int a, int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [3:0] st8();
    return {qd8, qm8, qs8, qi8};
  endfunction

  logic pd8 = 1'b0;
  logic pd16 = 1'b0;
  always @(negedge Clk) begin
    if (qd8 === 1'b1 && !pd8) begin
      if (exp8_q.size() == 0) chk("sb8_unexpected_done", 1, 0);
      else begin
        chk("sb8_gcd", g8, exp8_q.pop_front());
        chk("sb8_icount_at_done", ic8, 0);
      end
    end
    pd8 = (qd8 === 1'b1);
  end

  always @(negedge Clk) begin
    if (qd16 === 1'b1 && !pd16) begin
      if (exp16_q.size() == 0) chk("sb16_unexpected_done", 1, 0);
      else chk("sb16_gcd", g16, exp16_q.pop_front());
    end
    pd16 = (qd16 === 1'b1);
  end

  task automatic start_8(input logic [7:0] a, input logic [7:0] b);
    ain8 = a; bin8 = b; start8 = 1'b1;
    @(negedge Clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done_8(input int budget, output int n);
    n = 0;
    while (qd8 !== 1'b1 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (qd8 !== 1'b1) chk("timeout8", 0, 1);
  endtask

  task automatic ack_8();
    ack8 = 1'b1;
    @(negedge Clk);
    ack8 = 1'b0;
    chk("ack8_back_to_I", st8(), ST_I);
  endtask

  task automatic run_8(input logic [7:0] a, input logic [7:0] b);
    int n;
    exp8_q.push_back(ref_gcd(int'(a), int'(b)));
    start_8(a, b);
    wait_done_8(100, n);
    ack_8();
  endtask

  task automatic run_16(input logic [15:0] a, input logic [15:0] b);
    int n;
    exp16_q.push_back(ref_gcd(int'(a), int'(b)));
    ain16 = a; bin16 = b; start16 = 1'b1;
    @(negedge Clk);
    start16 = 1'b0;
    n = 0;
    while (qd16 !== 1'b1 && n < 300) begin
      @(negedge Clk);
      n++;
    end
    if (qd16 !== 1'b1) chk("timeout16", 0, 1);
    ack16 = 1'b1;
    @(negedge Clk);
    ack16 = 1'b0;
  endtask

  // 36/24 trace after each edge, starting with the SUB entry edge.
  int ta[9] = '{36, 18, 9, 9, 6, 3, 3, 6, 12};
  int tb[9] = '{24, 12, 6, 3, 3, 3, 3, 3, 3};
  int ti[9] = '{0, 1, 2, 2, 2, 2, 2, 1, 0};
  logic [3:0] ts[9] = '{ST_SUB, ST_SUB, ST_SUB, ST_SUB, ST_SUB, ST_SUB, ST_MULT, ST_MULT, ST_MULT};

  initial begin
    int n;
    Reset = 1'b1;
    cen8 = 1'b1; start8 = 1'b0; ack8 = 1'b0; ain8 = '0; bin8 = '0;
    cen16 = 1'b1; start16 = 1'b0; ack16 = 1'b0; ain16 = '0; bin16 = '0;
    repeat (2) @(negedge Clk);
    chk("reset_state", st8(), ST_I);
    chk("reset_A", a8, 0);
    chk("reset_B", b8, 0);
    chk("reset_gcd", g8, 0);
    chk("reset_icount", ic8, 0);
    Reset = 1'b0;

    // CEN=0 in I: Start ignored and operands not loaded.
    ain8 = 8'd36; bin8 = 8'd24; start8 = 1'b1; cen8 = 1'b0;
    @(negedge Clk);
    chk("cen0_start_ignored", st8(), ST_I);
    chk("cen0_A_held", a8, 0);
    start8 = 1'b0; cen8 = 1'b1;

    // Stepwise 36/24 trace.
    exp8_q.push_back(12);
    start_8(8'd36, 8'd24);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("trace_state_%0d", k), st8(), ts[k]);
      chk($sformatf("trace_A_%0d", k), a8, ta[k]);
      chk($sformatf("trace_B_%0d", k), b8, tb[k]);
      chk($sformatf("trace_i_%0d", k), ic8, ti[k]);
      @(negedge Clk);
    end
    chk("trace_done_after_9", st8(), ST_DONE);
`ifdef GCD_CYCLE_CNT_EN
    chk("trace_cycles", cyc8, 9);
`endif
    start8 = 1'b1;
    @(negedge Clk);
    chk("done_ignores_start", st8(), ST_DONE);
    chk("done_holds_A", a8, 12);
    start8 = 1'b0;
    ack8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk($sformatf("ack_held_I_%0d", k), st8(), ST_I);
    end
    ack8 = 1'b0;
    @(negedge Clk);
    chk("no_restart_without_start", st8(), ST_I);
    chk("gcd_kept_in_I", g8, 12);

    // 36/24 with a 5-clock CEN stall mid-SUB.
    exp8_q.push_back(12);
    start_8(8'd36, 8'd24);
    repeat (2) @(negedge Clk);
    cen8 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      chk($sformatf("stall_A_%0d", k), a8, 9);
      chk($sformatf("stall_B_%0d", k), b8, 6);
      chk($sformatf("stall_i_%0d", k), ic8, 2);
      chk($sformatf("stall_state_%0d", k), st8(), ST_SUB);
    end
    cen8 = 1'b1;
    wait_done_8(100, n);
    chk("stall_active_cycles", n + 2, 9);
`ifdef GCD_CYCLE_CNT_EN
    chk("stall_cycles_reg", cyc8, 9);
`endif
    ack_8();

    // Zero operands go straight to DONE.
    exp8_q.push_back(5);
    start_8(8'd0, 8'd5);
    chk("zero_op_direct_done", st8(), ST_DONE);
    ack_8();
    exp8_q.push_back(0);
    start_8(8'd0, 8'd0);
    chk("zero_zero_direct_done", st8(), ST_DONE);
    ack_8();

    // 255/255: one SUB clock, one MULT clock.
    exp8_q.push_back(255);
    start_8(8'd255, 8'd255);
    chk("eq_sub", st8(), ST_SUB);
    @(negedge Clk);
    chk("eq_mult", st8(), ST_MULT);
    @(negedge Clk);
    chk("eq_done", st8(), ST_DONE);
    ack_8();

    run_8(8'd17, 8'd13);
    run_8(8'd48, 8'd18);
    run_8(8'd64, 8'd32);
    run_8(8'd128, 8'd128);
    run_8(8'd1, 8'd255);
    run_8(8'd200, 8'd0);

    // Reset aborting a computation in SUB.
    start_8(8'd36, 8'd24);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort_state", st8(), ST_I);
    chk("abort_A", a8, 0);
    chk("abort_B", b8, 0);
    chk("abort_gcd", g8, 0);
    chk("abort_icount", ic8, 0);
    run_8(8'd36, 8'd24);

    // 16-bit instance.
    run_16(16'd65535, 16'd4369);
    for (int x = 2; x <= 63; x++)
      for (int y = 2; y <= 63; y += 3)
        run_16(16'(x), 16'(y));

    repeat (2) @(negedge Clk);
    chk("sb8_all_consumed", exp8_q.size(), 0);
    chk("sb16_all_consumed", exp16_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_param_core.md
Name: gcd_param_core

Overview:
- Parametrised successor to the 8-bit GCD core, implementing binary (Stein) GCD over WIDTH-bit unsigned operands.
- Extracts the common power of two into i_count, reduces odd parts by shift/subtract, then restores the power of two by left shifts.
- Uses the Start/Ack handshake and CEN single-step enable of the existing core, so it drops into the same top-level and testbench flow.
- Adds zero-operand handling and a wider data path.

Parameters:
- WIDTH, 8: operand and result width in bits.
- ICNT_W, 4: width of i_count. Must satisfy 2^ICNT_W > WIDTH.

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  Reset, synchronous, active-high; clock Clk.
- CEN  input  1  clock enable; 0 freezes state and all registers.
- Start  input  1  begin computation; sampled only in I.
- Ack  input  1  acknowledge result; sampled only in DONE.
- Ain  input  WIDTH  operand A.
- Bin  input  WIDTH  operand B.
- A  output  WIDTH  working register A.
- B  output  WIDTH  working register B.
- AB_GCD  output  WIDTH  result register.
- i_count  output  ICNT_W  count of common factors of two.
- q_I, q_Sub, q_Mult, q_Done  output  1 each  one-hot state flags.

Behaviour:
- Reset (CEN irrelevant): next edge enters I; A, B, AB_GCD, i_count = 0; q_I = 1, other flags 0. Reset mid-computation aborts and gives the same result.
- CEN=0: no register or state changes. Outputs hold. Start and Ack are ignored.
- All actions below apply only on edges with CEN=1.
- I:
  - Every edge: A<=Ain, B<=Bin, i_count<=0.
  - Start=1 and (Ain==0 or Bin==0): AB_GCD<=Ain|Bin, go to DONE. GCD(0,0)=0.
  - Start=1, both operands nonzero: go to SUB.
  - Start=0: stay in I.
- SUB: exactly one action per edge, first match wins:
  1. A==B: go to MULT, no data change.
  2. A and B both even: A<=A>>1, B<=B>>1, i_count<=i_count+1.
  3. A even: A<=A>>1.
  4. B even: B<=B>>1.
  5. A>B: A<=A-B.
  6. Otherwise: B<=B-A.
- MULT:
  - i_count!=0: A<=A<<1, i_count<=i_count-1.
  - i_count==0: AB_GCD<=A, go to DONE.
  - A never overflows WIDTH because the result is no larger than the smaller operand.
- DONE:
  - All registers hold.
  - Ack=1: go to I.
  - Ack held high across the return to I has no effect; Start is sampled again only in I.
  - Start in DONE is ignored.
- AB_GCD is written only on DONE entry. It keeps its value through I until the next DONE entry or Reset.
- Exactly one q_* flag is high at all times.

Optional Feature:
- Macro GCD_CYCLE_CNT_EN.
- When defined: adds output Cycles [15:0].
  - Cleared on the edge leaving I with Start.
  - Increments on every CEN=1 edge spent in SUB or MULT.
  - Saturates at 16'hFFFF and holds in DONE and I.
  - Reset clears it to 0.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, Ain=36, Bin=24, Start pulse → SUB sequence (18,12,i=1), (9,6,i=2), (9,3), (6,3), (3,3), equal. MULT gives A=6, then 12. AB_GCD=12, q_Done high 9 clocks after q_Sub first rises. Cycles=9 if GCD_CYCLE_CNT_EN.
- Ain=0, Bin=5, Start → DONE on the next edge with AB_GCD=5, q_Sub never asserted. Ain=0, Bin=0 → AB_GCD=0.
- Ain=255, Bin=255 → one SUB clock and one MULT clock, AB_GCD=255. Ain=17, Bin=13 (coprime) → AB_GCD=1, i_count=0 at DONE.
- Run 36/24 with CEN=0 for 5 clocks mid-SUB → A, B, i_count and state frozen during the stall. Final AB_GCD=12, cycles in SUB/MULT unchanged at 9.
- WIDTH=16, Ain=65535, Bin=4369 → AB_GCD=4369. Sweep Ain, Bin over 2..63 against a reference model → all results match.
- Reset asserted in SUB for one clock → I on the next edge with all outputs 0. Ack held high for 3 clocks in DONE → single return to I; no restart without Start.
